// File: rtl/envelope_generator.sv
// -----------------------------------------------------------------------------
// envelope_generator
//
// AY-3-8910-style envelope generator for the PSG datapath. It produces the
// 4-bit envelope level that feeds the attenuation stage's control input when a
// channel selects envelope mode. It advances only on the prescaler tick and
// supports the 16 standard shapes, encoded as continue/attack/alternate/hold.
//
// Ports:
//   clk      in   system clock (the only clock)
//   reset    in   asynchronous, active-high reset
//   enable   in   one-cycle prescaler tick (master/16); state advances only here
//   period   in   envelope period EP, sampled live; 0 behaves as 1
//   shape    in   {continue, attack, alternate, hold}
//   restart  in   one-cycle pulse on shape write: latches shape, restarts ramp
//   out      out  registered envelope level
//   held     out  high while the envelope is frozen
//
// Handshake: there is none. restart is a single-cycle strobe with no ready;
// it is accepted on every cycle it is high, with or without enable. Holding it
// high pins the envelope at phase 0.
// -----------------------------------------------------------------------------
module envelope_generator #(
  parameter int PERIOD_BITS  = 16,
  parameter int CONTROL_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_BITS-1:0]  period,
  input  logic [3:0]              shape,
  input  logic                    restart,
  output logic [CONTROL_BITS-1:0] out,
  output logic                    held
);

  localparam logic [CONTROL_BITS-1:0] LEVEL_MAX  = '1;
  localparam logic [CONTROL_BITS-1:0] LEVEL_ZERO = '0;

  // Bit positions inside the shape word.
  localparam int SHAPE_CONT = 3;
  localparam int SHAPE_ATT  = 2;
  localparam int SHAPE_ALT  = 1;
  localparam int SHAPE_HOLD = 0;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [PERIOD_BITS-1:0]  tick_cnt_q,   tick_cnt_d;
  logic [CONTROL_BITS-1:0] phase_q,      phase_d;
  logic                    dir_q,        dir_d;
  logic                    held_q,       held_d;
  logic [CONTROL_BITS-1:0] hold_level_q, hold_level_d;
  logic [3:0]              shape_q,      shape_d;
  logic [CONTROL_BITS-1:0] out_q,        out_d;

  // ---------------------------------------------------------------------------
  // Step tick
  // ---------------------------------------------------------------------------
  logic [PERIOD_BITS-1:0] period_eff;
  logic [PERIOD_BITS-1:0] period_last;
  logic                   step;

  // A zero period would never let the counter reach its terminal value, so it
  // is treated as 1 (one step per enable).
  assign period_eff  = (period == '0) ? PERIOD_BITS'(1) : period;
  assign period_last = period_eff - PERIOD_BITS'(1);

  // ">=" rather than "==" so that lowering period below the running count
  // still produces a step on the very next enable instead of wrapping.
  assign step = enable && (tick_cnt_q >= period_last);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    phase_d      = phase_q;
    dir_d        = dir_q;
    held_d       = held_q;
    hold_level_d = hold_level_q;
    shape_d      = shape_q;

    if (restart) begin
      // restart wins over a coincident step; that step is simply dropped.
      shape_d    = shape;
      dir_d      = shape[SHAPE_ATT];
      phase_d    = LEVEL_ZERO;
      held_d     = 1'b0;
      tick_cnt_d = '0;
    end else if (enable) begin
      // The period counter keeps running even while frozen.
      if (step) begin
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + PERIOD_BITS'(1);
      end

      if (step && !held_q) begin
        if (phase_q != LEVEL_MAX) begin
          phase_d = phase_q + CONTROL_BITS'(1);
        end else if (!shape_q[SHAPE_CONT]) begin
          // Shapes 0-7: single ramp, then silence.
          held_d       = 1'b1;
          hold_level_d = LEVEL_ZERO;
        end else if (shape_q[SHAPE_HOLD]) begin
          // Shapes 9/11/13/15: freeze at the end level, optionally flipped.
          held_d       = 1'b1;
          hold_level_d = (dir_q ^ shape_q[SHAPE_ALT]) ? LEVEL_MAX : LEVEL_ZERO;
        end else if (shape_q[SHAPE_ALT]) begin
          // Shapes 10/14: triangle, reverse direction each ramp.
          dir_d   = ~dir_q;
          phase_d = LEVEL_ZERO;
        end else begin
          // Shapes 8/12: sawtooth. Direction never toggles here, so it always
          // equals the latched attack bit.
          dir_d   = shape_q[SHAPE_ATT];
          phase_d = LEVEL_ZERO;
        end
      end
    end
  end

  // Output level is computed from next state so the registered out reflects
  // a step or restart on the edge that ends that cycle.
  always_comb begin
    out_d = LEVEL_ZERO;
    if (held_d) begin
      out_d = hold_level_d;
    end else if (dir_d) begin
      out_d = phase_d;
    end else begin
      out_d = LEVEL_MAX - phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q   <= '0;
      phase_q      <= LEVEL_ZERO;
      dir_q        <= 1'b0;
      held_q       <= 1'b1;
      hold_level_q <= LEVEL_ZERO;
      shape_q      <= 4'd0;
      out_q        <= LEVEL_ZERO;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      phase_q      <= phase_d;
      dir_q        <= dir_d;
      held_q       <= held_d;
      hold_level_q <= hold_level_d;
      shape_q      <= shape_d;
      out_q        <= out_d;
    end
  end

  assign out  = out_q;
  assign held = held_q;

endmodule

// File: tb/tb_envelope_generator.sv
// -----------------------------------------------------------------------------
// tb_envelope_generator
//
// Drives envelope_generator with directed sequences followed by random traffic.
// A reference model describes the envelope as a function of the number of
// steps taken since restart and the latched shape; the driver pushes the
// model's expected {held, out} for each clock into exp_q, and a monitor pops
// and compares once per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_envelope_generator;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic [3:0]  shape;
  logic        restart;
  logic [3:0]  out;
  logic        held;

  always #5 clk = ~clk;

  envelope_generator #(
    .PERIOD_BITS  (16),
    .CONTROL_BITS (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .period  (period),
    .shape   (shape),
    .restart (restart),
    .out     (out),
    .held    (held)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [4:0] exp_q[$];   // {held, level}
  int total = 0;
  int bad   = 0;

  // Reference model: shape latched at restart, steps taken since restart,
  // enables seen since the last step.
  int m_shape;
  int m_n;
  int m_tick;

  function automatic logic [4:0] model_out();
    int c, a, alt, h, r, p, rising;
    c   = (m_shape >> 3) & 1;
    a   = (m_shape >> 2) & 1;
    alt = (m_shape >> 1) & 1;
    h   = m_shape & 1;
    r   = m_n / 16;   // which ramp
    p   = m_n % 16;   // position within the ramp
    if (c == 0) begin
      if (m_n >= 16) return {1'b1, 4'd0};
      return {1'b0, 4'((a != 0) ? p : 15 - p)};
    end
    if (h == 1 && m_n >= 16) begin
      return {1'b1, ((a ^ alt) != 0) ? 4'd15 : 4'd0};
    end
    if (alt == 1 && h == 0) rising = a ^ (r % 2);
    else                    rising = a;
    return {1'b0, 4'((rising != 0) ? p : 15 - p)};
  endfunction

  task automatic model_cycle(input logic en, input logic rs);
    int pe;
    if (rs) begin
      m_shape = int'(shape);
      m_n     = 0;
      m_tick  = 0;
    end else if (en) begin
      pe = (period == 16'd0) ? 1 : int'(period);
      if (m_tick >= pe - 1) begin
        m_tick = 0;
        m_n++;
      end else begin
        m_tick++;
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [4:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({held, out} !== e) begin
        bad++;
        $display("FAIL env_out t=%0t: got held=%0d out=%0d, expected held=%0d out=%0d",
                 $time, held, out, e[4], e[3:0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic run_cycle(input logic en, input logic rs);
    enable  = en;
    restart = rs;
    model_cycle(en, rs);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  // Asserts reset away from any edge and checks that outputs clear at once.
  task automatic do_reset();
    @(negedge clk);
    #1;
    enable  = 1'b0;
    restart = 1'b0;
    reset   = 1'b1;
    #1;
    total++;
    if (out !== 4'd0 || held !== 1'b1) begin
      bad++;
      $display("FAIL async_reset t=%0t: got held=%0d out=%0d, expected held=1 out=0",
               $time, held, out);
    end
    m_shape = 0;
    m_n     = 16;
    m_tick  = 0;
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    restart = 1'b0;
    period  = 16'd1;
    shape   = 4'd0;
    m_shape = 0;
    m_n     = 16;
    m_tick  = 0;
    do_reset();

    // Shape 0, EP=1, enable tied high: 15..0 then frozen at 0.
    shape = 4'd0; period = 16'd1;
    run_cycle(1'b1, 1'b1);
    repeat (24) run_cycle(1'b1, 1'b0);

    // Shape 14 triangle, EP=2.
    shape = 4'd14; period = 16'd2;
    run_cycle(1'b1, 1'b1);
    repeat (140) run_cycle(1'b1, 1'b0);

    // Shapes 11 and 13, EP=1.
    shape = 4'd11; period = 16'd1;
    run_cycle(1'b1, 1'b1);
    repeat (24) run_cycle(1'b1, 1'b0);
    shape = 4'd13;
    run_cycle(1'b1, 1'b1);
    repeat (24) run_cycle(1'b1, 1'b0);

    // EP=0 with enable every third cycle.
    shape = 4'd10; period = 16'd0;
    run_cycle(1'b0, 1'b1);
    for (int i = 0; i < 120; i++) run_cycle((i % 3) == 2, 1'b0);

    // Restart colliding with a step at phase 7.
    shape = 4'd8; period = 16'd3;
    run_cycle(1'b1, 1'b1);
    for (int i = 0; i < 200 && !(m_n == 7 && m_tick == 2); i++) run_cycle(1'b1, 1'b0);
    shape = 4'd12;
    run_cycle(1'b1, 1'b1);
    repeat (12) run_cycle(1'b1, 1'b0);

    // Async reset mid-ramp.
    shape = 4'd12; period = 16'd1;
    run_cycle(1'b1, 1'b1);
    repeat (6) run_cycle(1'b1, 1'b0);
    do_reset();
    repeat (3) run_cycle(1'b1, 1'b0);

    // Period lowered below the running count.
    shape = 4'd8; period = 16'd100;
    run_cycle(1'b1, 1'b1);
    repeat (50) run_cycle(1'b1, 1'b0);
    period = 16'd10;
    repeat (60) run_cycle(1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic en, rs;
      en = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 60) == 0);
      if (rs) shape = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) period = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 999) == 0) do_reset();
      else run_cycle(en, rs);
    end

    // Every pushed expectation must have been consumed.
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/envelope_generator.md
# envelope_generator

Sequential AY-3-8910-style envelope generator for the PSG datapath. It produces the 4-bit envelope level that drives the attenuation stage's `control` input whenever a channel has envelope mode selected. The envelope runs on the PSG's prescaled tick, uses a 16-bit period, and supports the 16 standard shapes, encoded as continue, attack, alternate and hold.

## Interface
- `PERIOD_BITS`, 16, width of the envelope period.
- `CONTROL_BITS`, 4, width of the level output; equals the attenuation `CONTROL_BITS`.
- `clk` input 1: system clock; the block has one clock.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: one-cycle prescaler tick at master/16. The block only advances on cycles where it is high.
- `period` input `PERIOD_BITS`: envelope period EP. It is sampled live, and a value of 0 is treated as 1.
- `shape` input 4: bit 3 is continue (C), bit 2 attack (A), bit 1 alternate (Alt), bit 0 hold (H).
- `restart` input 1: one-cycle pulse issued when the shape register is written. It latches `shape` and restarts the envelope.
- `out` output `CONTROL_BITS`: registered envelope level, 0..15.
- `held` output 1: high while the envelope is frozen.

## Operation
- State:
  - `tick_cnt` is `PERIOD_BITS` wide.
  - `phase` is 4 bits.
  - `dir` is 1 bit: 1 means rising.
  - `held` is 1 bit.
  - `hold_level` is 4 bits.
  - `shape_q` is 4 bits.
- `out` equals `hold_level` when `held` is set. Otherwise it equals `phase` if `dir` is 1, and `15 - phase` if `dir` is 0.
- Step tick: a step fires on an `enable` cycle where `tick_cnt >= max(period,1) - 1`. On that cycle `tick_cnt` returns to 0; on other `enable` cycles it increments.
  - Comparing with `>=` covers the case where `period` is lowered below the current count. The step then fires on the next `enable`.
- On a step with `held` = 0 and `phase` < 15, `phase` increments.
- On a step with `held` = 0 and `phase` = 15 (end of ramp), the first matching rule applies:
  - C=0: set `held`=1 and `hold_level`=0. This covers shapes 0-7.
  - H=1: set `held`=1 and `hold_level` = (`dir` XOR Alt) ? 15 : 0. This covers shapes 9, 11, 13 and 15.
  - Alt=1: `dir` toggles and `phase` returns to 0. This gives the triangle shapes 10 and 14.
  - Otherwise: `phase` returns to 0 with `dir` unchanged. This gives the sawtooth shapes 8 and 12.
- While `held` is set, steps have no effect on `out`. `tick_cnt` keeps running.
- On `restart`:
  - `shape_q` latches `shape`.
  - `dir` becomes `shape[2]`.
  - `phase` becomes 0.
  - `held` becomes 0.
  - `tick_cnt` becomes 0.
- If `restart` and a step tick occur in the same cycle, `restart` wins and the step is discarded.
- `restart` is honoured regardless of `enable`.
- The shape rules above use `shape_q`, not the live `shape` input.
- Reset (asynchronous) values:
  - `tick_cnt`=0, `phase`=0, `dir`=0.
  - `held`=1 and `hold_level`=0, so `out`=0 and the `held` output is 1.
  - `shape_q`=0.

## Timing
- All outputs are registered. `out` updates on the clock edge that ends the step or restart cycle, so it is valid one cycle after that cycle.
- After `restart`, `out` is 15 if A=0 and 0 if A=1, starting from the next cycle.
- Each level lasts max(EP,1) `enable` ticks.
- One ramp lasts 16·max(EP,1) ticks, which is 256·EP master clocks, matching fE = fclk/(256·EP).
- For shapes with C=0, the freeze to 0 happens on the 16th step tick after restart.
- If `reset` is asserted in the middle of a ramp, all state clears immediately without needing a clock edge.
- There are no handshakes. `restart` must be a single-cycle pulse; a held-high `restart` keeps the envelope pinned at phase 0.

## Test plan
- **Reset, then shape 0:** reset, then `restart` with shape=0, EP=1 and `enable` tied high.
  - `out` goes 15,14,…,0 on consecutive cycles, then stays at 0.
  - `held` rises on the 16th step.
- **Shape 14, triangle:** `restart` with shape=14 and EP=2.
  - `out` is 0,0,1,1,…,15,15, then 15,15,14,14,…,0.
  - The pattern repeats with no hold.
- **Shape 11 and shape 13:** run each with EP=1.
  - Shape 11 ramps 15→0, then holds at 15 with `held`=1.
  - Shape 13 ramps 0→15, then holds at 15.
- **Period 0 and sparse enable:** EP=0 with `enable` pulsing every 3rd cycle.
  - `out` steps once per `enable` pulse, identical to EP=1.
- **Restart collision and mid-ramp reset:**
  - Assert `restart` (shape=12) in the same cycle as a step tick at phase 7. The next `out` is 0 and `tick_cnt` is 0.
  - Assert async `reset` mid-ramp. `out` becomes 0 and `held` becomes 1 before the next edge.
- **Period lowered mid-count:** set EP=100, wait 50 `enable` ticks, then change EP to 10.
  - A step fires on the next `enable`.
  - Later steps occur every 10 ticks.
